fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_stage_if.sv | 14 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 21;
  localparam int unsigned PC_INC  = 4;
  localparam int unsigned PC_W    = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/ack bus between the fetch stage and instruction memory.
interface fetch_stage_if
  import fetch_pkg::*;
#(
  parameter int unsigned N = 64
);
  logic               imem_req;
  logic [N-1:0]       imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two instruction buffer; flush dominates push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] FULL_C = CW'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == FULL_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !flush_i && !full_o;
  assign do_pop  = pop_i && !flush_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch front end: sequential PC generation, one-outstanding imem handshake,
// buffered hand-off to decode with stall absorption and branch redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned   N        = 64,
  parameter logic [N-1:0]  RESET_PC = '0,
  parameter int unsigned   DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  fetch_stage_if.master      imem,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [N-1:0]       br_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [N-1:0]       if_pc,
  output logic [10:0]        op
);
  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW:0] DEPTH_C = CW1'(DEPTH);

  fetch_state_t  state_q, state_d;
  logic [N-1:0]  pc_q, pc_d, req_addr_q, req_addr_d;
  logic [N-1:0]  br_pc, pc_inc;
  logic [CW-1:0] count;
  logic [CW:0]   count_after;
  logic          fifo_full, fifo_empty;
  logic          ack_fire, push, pop;
  fetch_entry_t  push_entry, head;
  logic          unused_br_lsbs;

  assign unused_br_lsbs = ^br_target[1:0];
  assign br_pc   = {br_target[N-1:2], 2'b00};
  assign pc_inc  = pc_q + N'(PC_INC);

  // Data is only accepted in REQ; acks in IDLE or DRAIN are ignored or dropped.
  assign ack_fire = (state_q == REQ) && imem.imem_ack;
  assign push     = ack_fire && !br_taken;
  assign pop      = if_valid && !stall && !br_taken;
  assign count_after = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};

  assign push_entry.pc    = PC_W'(req_addr_q);
  assign push_entry.instr = imem.imem_rdata;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (br_taken),
    .head_o      (head),
    .count_o     (count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    case (state_q)
      IDLE: begin
        if (br_taken) begin
          pc_d       = br_pc;
          req_addr_d = br_pc;
          state_d    = REQ;
        end else if (!fifo_full) begin
          req_addr_d = pc_q;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (br_taken) begin
          pc_d = br_pc;
          if (imem.imem_ack) req_addr_d = br_pc;
          else               state_d    = DRAIN;
        end else if (imem.imem_ack) begin
          pc_d = pc_inc;
          if (count_after < DEPTH_C) req_addr_d = pc_inc;
          else                       state_d    = IDLE;
        end
      end
      DRAIN: begin
        // The in-flight response belongs to a flushed path; wait it out, then restart.
        if (br_taken) pc_d = br_pc;
        if (imem.imem_ack) begin
          state_d    = REQ;
          req_addr_d = br_taken ? br_pc : pc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign imem.imem_req  = (state_q != IDLE);
  assign imem.imem_addr = req_addr_q;

  assign if_valid = !fifo_empty;
  assign if_instr = if_valid ? head.instr : '0;
  assign if_pc    = if_valid ? head.pc[N-1:0] : '0;
  assign op       = if_valid ? head.instr[OP_MSB:OP_LSB] : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected instruction stream derived from PC rules
// and an address-keyed memory image, checked by an independent monitor.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int unsigned  N        = 64;
  localparam logic [N-1:0] RESET_PC = '0;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          br_taken = 1'b0;
  logic [N-1:0]  br_target = '0;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [N-1:0]  if_pc;
  logic [10:0]   op;

  fetch_stage_if #(.N(N)) bus ();

  fetch_stage #(
    .N        (N),
    .RESET_PC (RESET_PC),
    .DEPTH    (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .imem      (bus),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .op        (op)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Memory image: low addresses hold LDUR-like words, elsewhere a hash of the word index.
  function automatic logic [31:0] mem_word(input logic [N-1:0] a);
    logic [N-1:0] idx;
    idx = a >> 2;
    if (a < 64'h1000) return 32'hF840_0000 + idx[31:0];
    return (idx[31:0] * 32'h9E37_79B1) ^ idx[63:32] ^ 32'h5A5A_1234;
  endfunction

  typedef struct {
    logic [N-1:0] pc;
    logic [31:0]  instr;
  } exp_t;
  exp_t exp_q[$];

  task automatic exp_top();
    logic [N-1:0] nx;
    while (exp_q.size() < 6) begin
      nx = exp_q[$].pc + 64'd4;
      exp_q.push_back('{nx, mem_word(nx)});
    end
  endtask

  task automatic exp_restart(input logic [N-1:0] a);
    exp_q.delete();
    exp_q.push_back('{a, mem_word(a)});
    exp_top();
  endtask

  // Memory responder: 0 = ack every request cycle, 1 = random with spurious acks, 2 = manual.
  int   mode    = 0;
  logic man_ack = 1'b0;
  always @(posedge clk) begin
    #2;
    case (mode)
      0:       bus.imem_ack = bus.imem_req;
      1:       bus.imem_ack = bus.imem_req ? ($urandom_range(2) != 0) : ($urandom_range(7) == 0);
      default: bus.imem_ack = man_ack;
    endcase
    bus.imem_rdata = bus.imem_req ? mem_word(bus.imem_addr) : $urandom();
  end

  // Monitor: pops the expected stream whenever decode consumes the head.
  logic         prev_rst = 1'b0, prev_br = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
  logic [N-1:0] prev_addr = '0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (prev_rst && prev_br) check("valid_after_redirect", if_valid, 1'b0);
      if (prev_rst && prev_req && !prev_ack) begin
        check("req_held", bus.imem_req, 1'b1);
        check("addr_stable", bus.imem_addr, prev_addr);
      end
      if (bus.imem_req) check("addr_aligned", bus.imem_addr[1:0], 2'b00);
      if (!if_valid) check("op_idle_zero", op, 11'h0);
      if (if_valid && !stall && !br_taken) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", if_pc, e.pc);
          check("pop_instr", if_instr, e.instr);
          check("pop_op", op, e.instr[31:21]);
          exp_top();
          n_pops++;
        end
      end
    end
    prev_rst  = reset;
    prev_br   = br_taken;
    prev_req  = bus.imem_req;
    prev_ack  = bus.imem_ack;
    prev_addr = bus.imem_addr;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] h;
    logic [N-1:0] tgt;
    int pops_before;

    // Reset state
    repeat (3) cyc();
    check("rst_req", bus.imem_req, 1'b0);
    check("rst_addr", bus.imem_addr, 64'h0);
    check("rst_valid", if_valid, 1'b0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_pc", if_pc, 64'h0);
    check("rst_op", op, 11'h0);
    reset = 1'b1;
    exp_restart(RESET_PC);

    // Straight-line flow, ack every cycle
    cyc();
    check("t1_first_req", bus.imem_req, 1'b1);
    check("t1_first_addr", bus.imem_addr, RESET_PC);
    cyc();
    check("t1_valid", if_valid, 1'b1);
    check("t1_pc0", if_pc, RESET_PC);
    check("t1_op_ldur", op, 11'h7C2);
    repeat (8) cyc();

    // Stall until the buffer fills, then release
    stall = 1'b1;
    repeat (5) cyc();
    check("t2_req_dropped", bus.imem_req, 1'b0);
    check("t2_valid", if_valid, 1'b1);
    h = if_pc;
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (bus.imem_req) break;
    end
    check("t2_req_resumed", bus.imem_req, 1'b1);
    check("t2_next_addr", bus.imem_addr, h + 64'd8);
    repeat (4) cyc();

    // Redirect with a slow response in flight -> DRAIN
    mode = 2; man_ack = 1'b0;
    reset = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    br_taken = 1'b1; br_target = 64'h10;
    exp_restart(64'h10);
    cyc();
    check("t3_req", bus.imem_req, 1'b1);
    check("t3_addr", bus.imem_addr, 64'h10);
    br_target = 64'h103;
    exp_restart(64'h100);
    cyc();
    br_taken = 1'b0;
    check("t3_drain_addr", bus.imem_addr, 64'h10);
    check("t3_drain_valid", if_valid, 1'b0);
    cyc();
    check("t3_drain_req", bus.imem_req, 1'b1);
    check("t3_drain_addr2", bus.imem_addr, 64'h10);
    man_ack = 1'b1;
    cyc();
    man_ack = 1'b0;
    mode = 0;
    check("t3_restart_req", bus.imem_req, 1'b1);
    check("t3_restart_addr", bus.imem_addr, 64'h100);
    check("t3_no_stale", if_valid, 1'b0);
    cyc();
    check("t3_first_valid", if_valid, 1'b1);
    check("t3_first_pc", if_pc, 64'h100);
    repeat (4) cyc();

    // Redirect coinciding with an ack while the buffer is occupied
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (!bus.imem_req) break;
    end
    check("t4_full_idle", bus.imem_req, 1'b0);
    mode = 2; man_ack = 1'b0; stall = 1'b0;
    cyc();
    stall = 1'b1;
    cyc();
    check("t4_req", bus.imem_req, 1'b1);
    check("t4_occupied", if_valid, 1'b1);
    man_ack = 1'b1; br_taken = 1'b1; br_target = 64'h40;
    exp_restart(64'h40);
    cyc();
    br_taken = 1'b0; man_ack = 1'b0;
    check("t4_flushed", if_valid, 1'b0);
    check("t4_req_after", bus.imem_req, 1'b1);
    check("t4_addr_after", bus.imem_addr, 64'h40);
    mode = 0; stall = 1'b0;
    repeat (4) cyc();

    // PC wrap at the top of the address space
    br_taken = 1'b1; br_target = '1;
    exp_restart({br_target[N-1:2], 2'b00});
    cyc();
    br_taken = 1'b0;
    check("t5_addr_top", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc();
    check("t5_addr_wrap", bus.imem_addr, 64'h0);
    repeat (3) cyc();

    // Asynchronous reset with data buffered
    stall = 1'b1;
    cyc(); cyc();
    check("t6_pre_valid", if_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_valid", if_valid, 1'b0);
    check("t6_req", bus.imem_req, 1'b0);
    check("t6_op", op, 11'h0);
    stall = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    exp_restart(RESET_PC);
    cyc();
    check("t6_first_req", bus.imem_req, 1'b1);
    check("t6_first_addr", bus.imem_addr, RESET_PC);

    // Randomized traffic
    pops_before = n_pops;
    mode = 1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      stall = ($urandom_range(99) < 30);
      if ($urandom_range(99) < 5) begin
        tgt = ($urandom_range(3) == 0) ? {$urandom(), $urandom()} : 64'($urandom_range(4095));
        br_taken = 1'b1; br_target = tgt;
        exp_restart({tgt[N-1:2], 2'b00});
      end else begin
        br_taken = 1'b0;
      end
    end
    br_taken = 1'b0; stall = 1'b0; mode = 0;
    repeat (10) cyc();
    check("rand_progress", (n_pops - pops_before) > 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
